// File: rtl/reg_pair_sequencer.sv
// rtl/reg_pair_sequencer.sv - register-pair MOV/INC/DEC/LD sequencer driving an 8-bit register file
module reg_pair_sequencer (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [2:0]  src_sel_i,
   input  logic [2:0]  dst_sel_i,
   input  logic [1:0]  pair_i,
   input  logic [15:0] imm16_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [15:0] result_o,
   output logic [2:0]  rf_wr_sel_o,
   output logic [2:0]  rf_rd_sel_o,
   output logic        rf_wr_en_o,
   output logic        rf_rd_en_o,
   output logic [7:0]  rf_wdata_o,
   input  logic [7:0]  rf_rdata_i
);

   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

   localparam logic [1:0] OP_MOV = 2'b00;
   localparam logic [1:0] OP_INC = 2'b01;
   localparam logic [1:0] OP_LD  = 2'b11;

   state_t      state_q;
   logic [1:0]  op_q;
   logic [2:0]  dst_q;
   logic [1:0]  pair_q;
   logic [7:0]  imm_hi_q;
   logic [7:0]  lo_q;
   logic [7:0]  hi_q;
   logic        busy_q;
   logic        done_q;
   logic        err_q;
   logic [15:0] result_q;
   logic [2:0]  rf_wr_sel_q;
   logic [2:0]  rf_rd_sel_q;
   logic        rf_wr_en_q;
   logic        rf_rd_en_q;
   logic [7:0]  rf_wdata_q;

   logic        invalid_d;
   logic [7:0]  lo_wr_d;
   logic [7:0]  hi_wr_d;

   // lo_q holds the byte read in RD_LO, then the byte written in WR_LO; carry/borrow comes from the latter
   always_comb begin
      invalid_d = 1'b0;
      lo_wr_d   = 8'h00;
      hi_wr_d   = 8'h00;
      if (op_i == OP_MOV) begin
         invalid_d = (src_sel_i == 3'b110) || (dst_sel_i == 3'b110);
      end else begin
         invalid_d = (pair_i == 2'b11);
      end
      lo_wr_d = (op_q == OP_INC) ? lo_q + 8'd1 : lo_q - 8'd1;
      if (op_q == OP_LD) begin
         hi_wr_d = imm_hi_q;
      end else if (op_q == OP_INC) begin
         hi_wr_d = hi_q + {7'd0, (lo_q == 8'h00)};
      end else begin
         hi_wr_d = hi_q - {7'd0, (lo_q == 8'hFF)};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         op_q        <= 2'b00;
         dst_q       <= 3'b000;
         pair_q      <= 2'b00;
         imm_hi_q    <= 8'h00;
         lo_q        <= 8'h00;
         hi_q        <= 8'h00;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         result_q    <= 16'h0000;
         rf_wr_sel_q <= 3'b000;
         rf_rd_sel_q <= 3'b000;
         rf_wr_en_q  <= 1'b0;
         rf_rd_en_q  <= 1'b0;
         rf_wdata_q  <= 8'h00;
      end else begin
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rf_wr_sel_q <= 3'b000;
         rf_rd_sel_q <= 3'b000;
         rf_wr_en_q  <= 1'b0;
         rf_rd_en_q  <= 1'b0;
         rf_wdata_q  <= 8'h00;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  op_q     <= op_i;
                  dst_q    <= dst_sel_i;
                  pair_q   <= pair_i;
                  imm_hi_q <= imm16_i[15:8];
                  busy_q   <= 1'b1;
                  if (invalid_d) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                  end else if (op_i == OP_MOV) begin
                     state_q     <= RD_LO;
                     rf_rd_en_q  <= 1'b1;
                     rf_rd_sel_q <= src_sel_i;
                  end else if (op_i == OP_LD) begin
                     state_q     <= WR_LO;
                     lo_q        <= imm16_i[7:0];
                     rf_wr_en_q  <= 1'b1;
                     rf_wr_sel_q <= {pair_i, 1'b1};
                     rf_wdata_q  <= imm16_i[7:0];
                  end else begin
                     state_q     <= RD_LO;
                     rf_rd_en_q  <= 1'b1;
                     rf_rd_sel_q <= {pair_i, 1'b1};
                  end
               end
            end
            RD_LO: begin
               lo_q <= rf_rdata_i;
               if (op_q == OP_MOV) begin
                  state_q     <= WR_LO;
                  rf_wr_en_q  <= 1'b1;
                  rf_wr_sel_q <= dst_q;
                  rf_wdata_q  <= rf_rdata_i;
               end else begin
                  state_q     <= RD_HI;
                  rf_rd_en_q  <= 1'b1;
                  rf_rd_sel_q <= {pair_q, 1'b0};
               end
            end
            RD_HI: begin
               hi_q        <= rf_rdata_i;
               lo_q        <= lo_wr_d;
               state_q     <= WR_LO;
               rf_wr_en_q  <= 1'b1;
               rf_wr_sel_q <= {pair_q, 1'b1};
               rf_wdata_q  <= lo_wr_d;
            end
            WR_LO: begin
               if (op_q == OP_MOV) begin
                  state_q  <= DONE;
                  done_q   <= 1'b1;
                  result_q <= {8'h00, lo_q};
               end else begin
                  state_q     <= WR_HI;
                  hi_q        <= hi_wr_d;
                  rf_wr_en_q  <= 1'b1;
                  rf_wr_sel_q <= {pair_q, 1'b0};
                  rf_wdata_q  <= hi_wr_d;
               end
            end
            WR_HI: begin
               state_q  <= DONE;
               done_q   <= 1'b1;
               result_q <= {hi_q, lo_q};
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign result_o    = result_q;
   assign rf_wr_sel_o = rf_wr_sel_q;
   assign rf_rd_sel_o = rf_rd_sel_q;
   assign rf_wr_en_o  = rf_wr_en_q;
   assign rf_rd_en_o  = rf_rd_en_q;
   assign rf_wdata_o  = rf_wdata_q;

endmodule

// File: tb/tb_reg_pair_sequencer.sv
// tb/tb_reg_pair_sequencer.sv - directed self-checking bench for reg_pair_sequencer
module tb_reg_pair_sequencer;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [1:0]  op_i = 2'b00;
   logic [2:0]  src_sel_i = 3'b000;
   logic [2:0]  dst_sel_i = 3'b000;
   logic [1:0]  pair_i = 2'b00;
   logic [15:0] imm16_i = 16'h0000;
   logic        busy_o, done_o, err_o, rf_wr_en_o, rf_rd_en_o;
   logic [15:0] result_o;
   logic [2:0]  rf_wr_sel_o, rf_rd_sel_o;
   logic [7:0]  rf_wdata_o, rf_rdata_i;

   logic [7:0]  rf [0:7];
   logic        pl_en = 1'b0;
   logic [2:0]  pl_sel = 3'b000;
   logic [7:0]  pl_data = 8'h00;
   int          wn_total = 0;
   int          rd_total = 0;
   int          done_total = 0;
   int          overlap = 0;
   int          idle_viol = 0;
   logic [2:0]  wlog_sel [0:255];
   logic [7:0]  wlog_dat [0:255];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_pair_sequencer dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
      .src_sel_i(src_sel_i), .dst_sel_i(dst_sel_i), .pair_i(pair_i), .imm16_i(imm16_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .result_o(result_o),
      .rf_wr_sel_o(rf_wr_sel_o), .rf_rd_sel_o(rf_rd_sel_o),
      .rf_wr_en_o(rf_wr_en_o), .rf_rd_en_o(rf_rd_en_o),
      .rf_wdata_o(rf_wdata_o), .rf_rdata_i(rf_rdata_i)
   );

   // register file model: combinational read, write on the rising edge
   assign rf_rdata_i = rf_rd_en_o ? rf[rf_rd_sel_o] : 8'h00;

   always @(posedge clk) begin
      if (pl_en) begin
         rf[pl_sel] = pl_data;
      end else if (rf_wr_en_o) begin
         rf[rf_wr_sel_o] = rf_wdata_o;
         wlog_sel[wn_total[7:0]] = rf_wr_sel_o;
         wlog_dat[wn_total[7:0]] = rf_wdata_o;
         wn_total++;
      end
      if (rf_rd_en_o) rd_total++;
   end

   always @(negedge clk) begin
      if (done_o) done_total++;
      if (rf_rd_en_o && rf_wr_en_o) overlap++;
      if (!rf_rd_en_o && rf_rd_sel_o != 3'b000) idle_viol++;
      if (!rf_wr_en_o && (rf_wr_sel_o != 3'b000 || rf_wdata_o != 8'h00)) idle_viol++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [2:0] sel, input logic [7:0] data);
      pl_sel = sel; pl_data = data; pl_en = 1'b1;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic run_op(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d,
                         input logic [1:0] p, input logic [15:0] imm,
                         output int lat, output logic e);
      op_i = op; src_sel_i = s; dst_sel_i = d; pair_i = p; imm16_i = imm;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      lat = -1; e = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if (done_o) begin
            lat = c; e = err_o;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   initial begin
      int lat, w0, r0, d0, d1, d2;
      logic e;
      logic [15:0] res1, res2;
      for (int i = 0; i < 8; i++) rf[i] = 8'h00;

      repeat (2) @(negedge clk);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_result", result_o, 0);
      chk("rst_wr_en", rf_wr_en_o, 0);
      chk("rst_rd_en", rf_rd_en_o, 0);
      chk("rst_sels", {rf_wr_sel_o, rf_rd_sel_o}, 0);
      chk("rst_wdata", rf_wdata_o, 0);
      rst_i = 1'b0;
      @(negedge clk);

      preload(3'b000, 8'h12); preload(3'b001, 8'hFF);
      preload(3'b100, 8'h00); preload(3'b101, 8'h00);
      preload(3'b111, 8'h5A);

      w0 = wn_total;
      run_op(2'b01, 3'b000, 3'b000, 2'b00, 16'h0000, lat, e);
      chk("inc_bc_lat", lat, 5);
      chk("inc_bc_err", e, 0);
      chk("inc_bc_result", result_o, 16'h1300);
      chk("inc_bc_nwr", wn_total - w0, 2);
      chk("inc_bc_wr0", {wlog_sel[w0[7:0]], wlog_dat[w0[7:0]]}, {3'b001, 8'h00});
      chk("inc_bc_wr1", {wlog_sel[w0[7:0] + 8'd1], wlog_dat[w0[7:0] + 8'd1]}, {3'b000, 8'h13});

      run_op(2'b10, 3'b000, 3'b000, 2'b10, 16'h0000, lat, e);
      chk("dec_hl_lat", lat, 5);
      chk("dec_hl_result", result_o, 16'hFFFF);
      chk("dec_hl_regs", {rf[4], rf[5]}, 16'hFFFF);

      w0 = wn_total; r0 = rd_total;
      run_op(2'b11, 3'b000, 3'b000, 2'b01, 16'hBEEF, lat, e);
      chk("ld_de_lat", lat, 3);
      chk("ld_de_nrd", rd_total - r0, 0);
      chk("ld_de_wr0", {wlog_sel[w0[7:0]], wlog_dat[w0[7:0]]}, {3'b011, 8'hEF});
      chk("ld_de_wr1", {wlog_sel[w0[7:0] + 8'd1], wlog_dat[w0[7:0] + 8'd1]}, {3'b010, 8'hBE});
      chk("ld_de_result", result_o, 16'hBEEF);

      w0 = wn_total; r0 = rd_total;
      run_op(2'b00, 3'b111, 3'b101, 2'b00, 16'h0000, lat, e);
      chk("mov_al_lat", lat, 3);
      chk("mov_al_l", rf[5], 8'h5A);
      chk("mov_al_result", result_o, 16'h005A);
      chk("mov_al_nrdwr", {rd_total - r0, wn_total - w0}, {32'd1, 32'd1});

      w0 = wn_total; r0 = rd_total;
      run_op(2'b00, 3'b110, 3'b000, 2'b00, 16'h0000, lat, e);
      chk("mov_bad_lat", lat, 1);
      chk("mov_bad_err", e, 1);
      chk("mov_bad_norf", (wn_total - w0) + (rd_total - r0), 0);
      chk("mov_bad_result_held", result_o, 16'h005A);

      w0 = wn_total;
      run_op(2'b01, 3'b000, 3'b000, 2'b11, 16'h0000, lat, e);
      chk("inc_bad_pair", {lat[7:0], 7'd0, e}, {8'd1, 8'd1});
      chk("inc_bad_norf", wn_total - w0, 0);

      preload(3'b000, 8'hFF); preload(3'b001, 8'hFF);
      run_op(2'b01, 3'b000, 3'b000, 2'b00, 16'h0000, lat, e);
      chk("inc_wrap_result", result_o, 16'h0000);
      chk("inc_wrap_regs", {rf[0], rf[1]}, 16'h0000);

      w0 = wn_total; r0 = rd_total;
      run_op(2'b00, 3'b111, 3'b111, 2'b00, 16'h0000, lat, e);
      chk("mov_aa_nrdwr", {rd_total - r0, wn_total - w0}, {32'd1, 32'd1});
      chk("mov_aa_result", result_o, 16'h005A);

      op_i = 2'b11; pair_i = 2'b00; imm16_i = 16'h7777;
      rst_i = 1'b1; start_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0; start_i = 1'b0;
      chk("rst_over_start", busy_o, 0);
      @(negedge clk);
      chk("rst_over_start_idle", {busy_o, rf_wr_en_o}, 0);

      preload(3'b100, 8'h22); preload(3'b101, 8'hFF);
      w0 = wn_total;
      op_i = 2'b01; pair_i = 2'b10; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_in_wr_lo", {busy_o, rf_wr_en_o, rf_wr_sel_o, rf_wdata_o}, {1'b1, 1'b1, 3'b101, 8'h00});
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      chk("abort_busy", {busy_o, rf_wr_en_o}, 0);
      d0 = done_total;
      repeat (6) @(negedge clk);
      chk("abort_no_done", done_total - d0, 0);
      chk("abort_one_write", wn_total - w0, 1);
      chk("abort_regs", {rf[4], rf[5]}, 16'h2200);

      w0 = wn_total; d1 = -1; d2 = -1; res1 = 16'h0; res2 = 16'h0;
      op_i = 2'b11; pair_i = 2'b00; imm16_i = 16'h1234; start_i = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) begin
            pair_i = 2'b01; imm16_i = 16'hABCD;
         end
         if (done_o) begin
            if (d1 < 0) begin d1 = c; res1 = result_o; end
            else begin d2 = c; res2 = result_o; end
         end
         if (c == 8) start_i = 1'b0;
      end
      @(negedge clk);
      chk("b2b_done_first", d1, 3);
      chk("b2b_done_second", d2, 7);
      chk("b2b_results", {res1, res2}, {16'h1234, 16'hABCD});
      chk("b2b_regs", {rf[0], rf[1], rf[2], rf[3]}, 32'h1234ABCD);
      chk("b2b_nwr", wn_total - w0, 4);
      chk("b2b_idle_after", busy_o, 0);

      chk("rd_wr_exclusive", overlap, 0);
      chk("idle_outputs_zero", idle_viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
